serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per cycle, LSB first, via a 3-state FSM.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH:0]   diff_ext;

  // Operands shift right so bit 0 of each register is always the bit being processed.
  assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign diff_ext = {d_bit, diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            diff    <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_next;
          diff  <= diff_ext[WIDTH:1];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            bout    <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // br_q is the borrow into the MSB on this final step.
            ovf     <= br_q ^ br_next;
`endif
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations on an 8-bit
// instance plus a full truth-table sweep on a 1-bit instance, checked against an arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf8, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular and signed arithmetic for a w-bit subtraction.
  function automatic void model(input int w, input longint ua, input longint ub, input int ubin,
                                output longint d, output bit bo, output bit ov);
    longint m, sa, sb, r;
    m  = longint'(1) << w;
    d  = (((ua - ub - ubin) % m) + m) % m;
    bo = (ua < ub + ubin);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb - ubin;
    ov = (r < -(m / 2)) || (r > (m / 2) - 1);
  endfunction

  // Runs one 8-bit operation; optionally disturbs start/a/b/bin mid-run.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input bit disturb, input string tag);
    longint ed;
    bit     eb, eo;
    int     edges, busy_cycles;
    model(8, longint'(ta), longint'(tb), int'(tbin), ed, eb, eo);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    busy_cycles = 0;
    while (done8 !== 1'b1 && edges < 20) begin
      if (busy8 === 1'b1) busy_cycles++;
      if (disturb && edges == 3) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = ~tbin;
      end
      if (disturb && edges == 4) start8 = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd8);
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
    check({tag, " diff"}, 32'(diff8), 32'(ed));
    check({tag, " bout"}, 32'(bout8), 32'(eb));
    check({tag, " busy_at_done"}, 32'(busy8), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, " ovf"}, 32'(ovf8), 32'(eo));
`endif
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done8), 32'd0);
    check({tag, " diff_held"}, 32'(diff8), 32'(ed));
  endtask

  initial begin
    longint ed;
    bit     eb, eo;
    int     edges;
    bit     saw_done;

    // Reset state, sampled while reset is still asserted.
    #12;
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst diff", 32'(diff8), 32'd0);
    check("rst bout", 32'(bout8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h05, 8'h03, 1'b0, 1'b0, "5-3");
    op8(8'h03, 8'h05, 1'b0, 1'b0, "3-5");
    op8(8'h00, 8'h00, 1'b1, 1'b0, "0-0-1");
    op8(8'h80, 8'h01, 1'b0, 1'b0, "80-1");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "7F-1");
    op8(8'h5A, 8'h33, 1'b1, 1'b1, "disturbed");

    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    // A start held high is accepted again in the IDLE cycle after DONE.
    a8 = 8'hC4; b8 = 8'h29; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (done8 !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("held latency", 32'(edges), 32'd8);
    @(posedge clk); #1;
    check("held idle busy", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    check("held restart busy", 32'(busy8), 32'd1);
    start8 = 1'b0;
    edges = 0;
    while (done8 !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("held second latency", 32'(edges), 32'd8);
    check("held second diff", 32'(diff8), 32'h9B);
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts without a done pulse.
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy8), 32'd0);
    check("midrst diff", 32'(diff8), 32'd0);
    check("midrst done", 32'(done8), 32'd0);
    check("midrst bout", 32'(bout8), 32'd0);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) saw_done = 1'b1;
    end
    check("midrst no_done", 32'(saw_done), 32'd0);
    op8(8'h10, 8'h20, 1'b1, 1'b0, "after_rst");

    // WIDTH=1 truth-table sweep.
    for (int v = 0; v < 8; v++) begin
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); bin1 = 1'(v);
      model(1, longint'(a1), longint'(b1), int'(bin1), ed, eb, eo);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      edges = 0;
      while (done1 !== 1'b1 && edges < 10) begin
        @(posedge clk); #1;
        edges++;
      end
      check($sformatf("w1 v%0d latency", v), 32'(edges), 32'd1);
      check($sformatf("w1 v%0d diff", v), 32'(diff1), 32'(ed));
      check($sformatf("w1 v%0d bout", v), 32'(bout1), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check($sformatf("w1 v%0d ovf", v), 32'(ovf1), 32'(eo));
`endif
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
